// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encodings and default sizing for the button debouncer
package btn_pkg;

    // Per-channel debounce state encodings
    localparam logic [1:0] ST_LOW   = 2'b00;
    localparam logic [1:0] CHK_HIGH = 2'b01;
    localparam logic [1:0] ST_HIGH  = 2'b10;
    localparam logic [1:0] CHK_LOW  = 2'b11;

    // Default counter width and acceptance window (100 us at a 10 ns clock)
    localparam int DEF_NB_COUNTER      = 14;
    localparam int DEF_DEBOUNCE_CYCLES = 10000;

endpackage

// File: rtl/btn_debounce_cell.sv
// rtl/btn_debounce_cell.sv - one debounce channel: optional BTN_SYNC_EN synchronizer, FSM, window counter, pulses
module btn_debounce_cell
    import btn_pkg::*;
#(
    parameter int NB_COUNTER      = DEF_NB_COUNTER,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // Value the counter holds on the last sample of a full window
    localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);
    localparam logic [NB_COUNTER-1:0] CNT_ONE  = NB_COUNTER'(1);

    logic s;

`ifdef BTN_SYNC_EN
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Two-flop synchronizer in front of the state machine
    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
    end

    // Synchronizer registers, cleared by reset
    always_ff @(posedge clock) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = i_btn;
`endif

    logic [1:0]            state_q, state_d;
    logic [NB_COUNTER-1:0] cnt_q, cnt_d;
    logic                  level_q, level_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;

    // Next-state logic: a new level must be seen on DEBOUNCE_CYCLES consecutive samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_LOW: begin
                cnt_d = '0;
                if (s) begin
                    state_d = CHK_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HIGH: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = CHK_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LOW: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; reset discards any partial window
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - NB_BTN independent debounce channels; BTN_SYNC_EN adds input synchronizers
module btn_debouncer
    import btn_pkg::*;
#(
    parameter int NB_BTN          = 4,
    parameter int NB_COUNTER      = DEF_NB_COUNTER,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_BTN-1:0] o_btn_rise,
    output logic [NB_BTN-1:0] o_btn_fall
);

    // One self-contained channel per button bit
    for (genvar k = 0; k < NB_BTN; k++) begin : g_ch
        btn_debounce_cell #(
            .NB_COUNTER      (NB_COUNTER),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_cell (
            .clock   (clock),
            .i_reset (i_reset),
            .i_btn   (i_btn[k]),
            .o_level (o_btn_level[k]),
            .o_rise  (o_btn_rise[k]),
            .o_fall  (o_btn_fall[k])
        );
    end

endmodule
